// File: rtl/sr_regdump_uart.sv
// sr_regdump_uart: sweeps the core debug read port and streams each register out as UART 8N1 frames.
// Build option: define SR_REGDUMP_HEX_EN to send each register as 8 uppercase hex digits plus CR LF
// instead of 4 raw little-endian bytes.
module sr_regdump_uart #(
   parameter int CLK_DIV   = 434,
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [4:0]  regAddr,
   input  logic [31:0] regData,
   output logic        tx,
   output logic        busy,
   output logic        done
);
`ifdef SR_REGDUMP_HEX_EN
   localparam logic [3:0] LAST_BYTE = 4'd9;
`else
   localparam logic [3:0] LAST_BYTE = 4'd3;
`endif
   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
   typedef enum logic [2:0] {IDLE, ADDR, LOAD, START_BIT, DATA_BIT, STOP_BIT} state_t;
   state_t      state, stateNext;
   logic [15:0] baudCnt;
   logic [2:0]  bitCnt;
   logic [3:0]  byteCnt;
   logic [4:0]  regIdx, idxNext;
   logic [31:0] shadow, shadowNext;
   logic [7:0]  curByte;
   logic        cellEnd, frameEnd, lastFrame, lastReg;
   // Next-state decode, register index advance and the serial bit being driven
   always_comb begin
      cellEnd = baudCnt == DIV_M1;
      frameEnd = (state == STOP_BIT) && cellEnd;
      lastFrame = frameEnd && (byteCnt == LAST_BYTE);
      lastReg = regIdx == 5'(LAST_REG);
      idxNext = (state == IDLE && start) ? 5'(FIRST_REG) : (lastFrame && !lastReg) ? regIdx + 5'd1 : regIdx;
      stateNext = state;
      case (state)
         IDLE:      stateNext = start ? ADDR : IDLE;
         ADDR:      stateNext = LOAD;
         LOAD:      stateNext = START_BIT;
         START_BIT: stateNext = cellEnd ? DATA_BIT : START_BIT;
         DATA_BIT:  stateNext = (cellEnd && bitCnt == 3'd7) ? STOP_BIT : DATA_BIT;
         STOP_BIT:  stateNext = !cellEnd ? STOP_BIT : (byteCnt != LAST_BYTE) ? START_BIT : lastReg ? IDLE : ADDR;
         default:   stateNext = IDLE;
      endcase
`ifdef SR_REGDUMP_HEX_EN
      curByte = (byteCnt == 4'd8) ? 8'h0D : (byteCnt == 4'd9) ? 8'h0A :
                (shadow[31:28] < 4'd10) ? {4'h3, shadow[31:28]} : 8'h37 + {4'h0, shadow[31:28]};
      shadowNext = {shadow[27:0], 4'h0};
`else
      curByte = shadow[7:0];
      shadowNext = {8'h00, shadow[31:8]};
`endif
      busy = state != IDLE;
      tx = (state == START_BIT) ? 1'b0 : (state == DATA_BIT) ? curByte[bitCnt] : 1'b1;
   end
   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= stateNext;
   end
   // Baud/bit/byte counters, register index, address output, shadow word and done pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         baudCnt <= '0;
         bitCnt <= '0;
         byteCnt <= '0;
         regIdx <= '0;
         regAddr <= '0;
         shadow <= '0;
         done <= 1'b0;
      end else begin
         baudCnt <= ((state == START_BIT || state == DATA_BIT || state == STOP_BIT) && !cellEnd) ? baudCnt + 16'd1 : '0;
         bitCnt <= (state == DATA_BIT) ? (cellEnd ? bitCnt + 3'd1 : bitCnt) : '0;
         byteCnt <= (state == LOAD) ? '0 : frameEnd ? byteCnt + 4'd1 : byteCnt;
         regIdx <= idxNext;
         regAddr <= (stateNext == ADDR) ? idxNext : regAddr;
         shadow <= (state == LOAD) ? regData : frameEnd ? shadowNext : shadow;
         done <= lastFrame && lastReg;
      end
   end
endmodule

// File: tb/tb_sr_regdump_uart.sv
// tb_sr_regdump_uart: scoreboard bench for sr_regdump_uart (single-register and full-sweep instances).
module tb_sr_regdump_uart;
   logic        clk = 1'b0, rst_n = 1'b0, startA = 1'b0, startB = 1'b0;
   logic [4:0]  regAddrA, regAddrB;
   logic [31:0] regDataA, regDataB;
   logic        txA, txB, busyA, busyB, doneA, doneB;
   int          checks = 0, failures = 0;
   logic [7:0]  expA[$], expB[$];
`ifdef SR_REGDUMP_HEX_EN
   localparam int FRAMES = 10;
`else
   localparam int FRAMES = 4;
`endif
   localparam int REG_CYC = 2 + FRAMES * 40;

   always #5 clk = ~clk;

   assign regDataA = (regAddrA == 5'd5) ? 32'h12345678 : 32'hDEADBEEF;
   assign regDataB = 32'hA5000000 | {27'd0, regAddrB};

   sr_regdump_uart #(.CLK_DIV(4), .FIRST_REG(5), .LAST_REG(5)) dutA (
      .clk(clk), .rst_n(rst_n), .start(startA), .regAddr(regAddrA), .regData(regDataA),
      .tx(txA), .busy(busyA), .done(doneA));
   sr_regdump_uart #(.CLK_DIV(4), .FIRST_REG(0), .LAST_REG(31)) dutB (
      .clk(clk), .rst_n(rst_n), .start(startB), .regAddr(regAddrB), .regData(regDataB),
      .tx(txB), .busy(busyB), .done(doneB));

   function automatic logic txOf(input int w);
      return (w == 0) ? txA : txB;
   endfunction

   task automatic pushByte(input int w, input logic [7:0] b);
      if (w == 0) expA.push_back(b);
      else expB.push_back(b);
   endtask

   task automatic pushWord(input int w, input logic [31:0] d);
      logic [3:0] nib;
`ifdef SR_REGDUMP_HEX_EN
      for (int i = 7; i >= 0; i--) begin
         nib = d[i*4 +: 4];
         pushByte(w, (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h41 + {4'h0, nib} - 8'd10);
      end
      pushByte(w, 8'h0D);
      pushByte(w, 8'h0A);
`else
      nib = 4'h0;
      for (int i = 0; i < 4; i++) pushByte(w, d[i*8 +: 8]);
`endif
   endtask

   // UART receiver: every cell must hold one level for exactly 4 samples
   task automatic monFrame(input int w);
      logic [7:0] b, e;
      logic v0, cur;
      bit bad;
      b = '0; v0 = 1'b0; bad = 0;
      @(negedge clk);
      if (!rst_n || txOf(w) !== 1'b0) return;
      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < 4; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (!rst_n) return;
            cur = txOf(w);
            if (j == 0) v0 = cur;
            else if (cur !== v0) bad = 1;
            if (k == 0 && cur !== 1'b0) bad = 1;
            if (k == 9 && cur !== 1'b1) bad = 1;
            if (k >= 1 && k <= 8) b[k-1] = cur;
         end
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL frame_timing dut=%0d got byte=%02h with a malformed cell, want 4-cycle cells", w, b);
      end
      checks++;
      if ((w == 0 && expA.size() == 0) || (w == 1 && expB.size() == 0)) begin
         failures++;
         $display("FAIL unexpected_byte dut=%0d got=%02h want=none", w, b);
      end else begin
         if (w == 0) e = expA.pop_front();
         else e = expB.pop_front();
         if (b !== e) begin
            failures++;
            $display("FAIL byte dut=%0d got=%02h want=%02h", w, b, e);
         end
      end
   endtask

   initial forever monFrame(0);
   initial forever monFrame(1);

   task automatic pulseStart(input int w);
      @(negedge clk);
      if (w == 0) startA = 1'b1;
      else startB = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      startB = 1'b0;
   endtask

   task automatic test_reset;
      int low;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({txA, busyA, doneA, regAddrA} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
         failures++;
         $display("FAIL reset_a got tx=%b busy=%b done=%b addr=%0d want 1 0 0 0", txA, busyA, doneA, regAddrA);
      end
      checks++;
      if ({txB, busyB, doneB, regAddrB} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
         failures++;
         $display("FAIL reset_b got tx=%b busy=%b done=%b addr=%0d want 1 0 0 0", txB, busyB, doneB, regAddrB);
      end
      rst_n = 1'b1;
      low = 0;
      repeat (1000) begin
         @(negedge clk);
         if (txA !== 1'b1 || txB !== 1'b1 || busyA !== 1'b0 || busyB !== 1'b0) low++;
      end
      checks++;
      if (low != 0) begin
         failures++;
         $display("FAIL idle_line got=%0d non-idle cycles want=0", low);
      end
   endtask

   task automatic test_single;
      int n, addrBad;
      pushWord(0, 32'h12345678);
      pulseStart(0);
      n = 0; addrBad = 0;
      while (busyA === 1'b1 && n < 20000) begin
         n++;
         if (regAddrA !== 5'd5) addrBad++;
         @(negedge clk);
      end
      checks++;
      if (n != REG_CYC) begin
         failures++;
         $display("FAIL single_busy_len got=%0d want=%0d", n, REG_CYC);
      end
      checks++;
      if (addrBad != 0) begin
         failures++;
         $display("FAIL single_regaddr got=%0d bad cycles want=0", addrBad);
      end
      checks++;
      if (doneA !== 1'b1 || busyA !== 1'b0) begin
         failures++;
         $display("FAIL single_done got done=%b busy=%b want done=1 busy=0", doneA, busyA);
      end
      @(negedge clk);
      checks++;
      if (doneA !== 1'b0) begin
         failures++;
         $display("FAIL single_done_width got=%b want=0", doneA);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (expA.size() != 0) begin
         failures++;
         $display("FAIL single_missing got=%0d pending bytes want=0", expA.size());
      end
   endtask

   task automatic test_full_sweep;
      int n, addrBad, expAddr;
      for (int a = 0; a < 32; a++) pushWord(1, 32'hA5000000 | a);
      pulseStart(1);
      n = 0; addrBad = 0; expAddr = 0;
      while (busyB === 1'b1 && n < 20000) begin
         n++;
         if (int'(regAddrB) == expAddr + 1) expAddr++;
         else if (int'(regAddrB) != expAddr) addrBad++;
         @(negedge clk);
      end
      checks++;
      if (n != 32 * REG_CYC) begin
         failures++;
         $display("FAIL sweep_busy_len got=%0d want=%0d", n, 32 * REG_CYC);
      end
      checks++;
      if (addrBad != 0 || expAddr != 31) begin
         failures++;
         $display("FAIL sweep_regaddr got last=%0d bad=%0d want last=31 bad=0", expAddr, addrBad);
      end
      checks++;
      if (doneB !== 1'b1) begin
         failures++;
         $display("FAIL sweep_done got=%b want=1", doneB);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (expB.size() != 0) begin
         failures++;
         $display("FAIL sweep_missing got=%0d pending bytes want=0", expB.size());
      end
   endtask

   task automatic test_ignore_start;
      int dones, n;
      pushWord(0, 32'h12345678);
      pulseStart(0);
      dones = 0;
      for (int c = 1; c <= 400; c++) begin
         startA = (c % 50 == 0 && c <= 150) ? 1'b1 : 1'b0;
         if (doneA === 1'b1) dones++;
         @(negedge clk);
      end
      startA = 1'b0;
      checks++;
      if (dones != 1) begin
         failures++;
         $display("FAIL ignore_start_dones got=%0d want=1", dones);
      end
      pushWord(0, 32'h12345678);
      pushWord(0, 32'h12345678);
      startA = 1'b1;
      n = 0;
      while (doneA !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (doneA !== 1'b1) begin
         failures++;
         $display("FAIL held_first_done got=%b want=1 (timeout)", doneA);
      end
      @(negedge clk);
      checks++;
      if (busyA !== 1'b1) begin
         failures++;
         $display("FAIL held_restart got busy=%b want=1", busyA);
      end
      startA = 1'b0;
      n = 0;
      while (doneA !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (doneA !== 1'b1) begin
         failures++;
         $display("FAIL held_second_done got=%b want=1 (timeout)", doneA);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (expA.size() != 0) begin
         failures++;
         $display("FAIL held_missing got=%0d pending bytes want=0", expA.size());
      end
   endtask

   task automatic test_reset_mid;
      int sawDone;
      for (int a = 0; a < 32; a++) pushWord(1, 32'hA5000000 | a);
      pulseStart(1);
      sawDone = 0;
      repeat (59) begin
         @(negedge clk);
         if (doneB === 1'b1) sawDone++;
      end
      checks++;
      if (txB !== 1'b0 || busyB !== 1'b1) begin
         failures++;
         $display("FAIL mid_bit3 got tx=%b busy=%b want tx=0 busy=1", txB, busyB);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({txB, busyB, regAddrB} !== {1'b1, 1'b0, 5'd0}) begin
         failures++;
         $display("FAIL mid_reset got tx=%b busy=%b addr=%0d want 1 0 0", txB, busyB, regAddrB);
      end
      rst_n = 1'b1;
      expB.delete();
      repeat (20) begin
         @(negedge clk);
         if (doneB === 1'b1) sawDone++;
      end
      checks++;
      if (sawDone != 0) begin
         failures++;
         $display("FAIL mid_no_done got=%0d pulses want=0", sawDone);
      end
      test_full_sweep();
   endtask

   initial begin
      test_reset();
      test_single();
      test_full_sweep();
      test_ignore_start();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
